// File: rtl/adc_pkt_unpack_if.sv
// Byte stream carrying AD7606 sample packets from the capture path.
// The master drives data/len/last/valid; the slave (the unpacker) only listens.
// There is no backpressure, so the bundle has no ready signal.
interface adc_pkt_unpack_if;
    logic [7:0] adc_data;   // packet byte
    logic [7:0] adc_len;    // total packet length, stable for the whole packet
    logic       adc_last;   // final byte of the packet
    logic       adc_valid;  // byte qualifier, gaps allowed

    modport master (
        output adc_data,
        output adc_len,
        output adc_last,
        output adc_valid
    );

    modport slave (
        input  adc_data,
        input  adc_len,
        input  adc_last,
        input  adc_valid
    );
endinterface

// File: rtl/adc_pkt_unpack.sv
// Parses AD7606 sample packets back into per-channel 16-bit samples.
// Packet: header, channel mask, then {MSB,LSB} for each set mask bit in
// ascending channel order. Framing is checked against the length field and
// the last flag; every framing error gives one err pulse and bumps a
// saturating error counter. A bad packet is discarded up to its last byte.
module adc_pkt_unpack #(
    parameter logic [7:0] P_HEADER = 8'hA5,
    parameter int         P_ERR_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    adc_pkt_unpack_if.slave    adc_in,
    output logic [2:0]         o_chnl_idx,
    output logic [15:0]        o_chnl_data,
    output logic               o_chnl_valid,
    output logic               o_pkt_done,
    output logic               o_pkt_err,
    output logic [P_ERR_W-1:0] o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,   // waiting for a header byte
        S_MASK = 3'd1,   // next byte is the channel mask
        S_HI   = 3'd2,   // next byte is the sample MSB of ch_reg
        S_LO   = 3'd3,   // next byte is the sample LSB of ch_reg
        S_DROP = 3'd4    // discarding a broken packet until its last byte
    } state_t;

    // Bit-select patterns used to binary-encode a one-hot channel vector.
    localparam logic [7:0] C_ENC_SEL [3] = '{8'hAA, 8'hCC, 8'hF0};

    state_t              state_reg;
    logic [7:0]          len_reg;        // length field latched at the header
    logic [7:0]          work_mask_reg;  // channels still to be received
    logic [2:0]          ch_reg;         // channel of the sample in flight
    logic [7:0]          msb_reg;        // stored MSB of the sample in flight
    logic [2:0]          chnl_idx_reg;
    logic [15:0]         chnl_data_reg;
    logic                chnl_valid_reg;
    logic                pkt_done_reg;
    logic                pkt_err_reg;
    logic [P_ERR_W-1:0]  err_cnt_reg;

    logic [3:0]          mask_pop;       // popcount of the incoming byte
    logic [8:0]          exp_len;        // 2 + 2*popcount, kept 9 bits wide
    logic                len_bad;
    logic [7:0]          ch_onehot;      // ch_reg as a one-hot vector
    logic [7:0]          rem_mask;       // working mask with ch_reg removed
    logic [7:0]          pick_vec;       // vector to search for the next channel
    logic [7:0]          pick_onehot;    // lowest set bit of pick_vec
    logic [2:0]          pick_idx;       // index of that bit

    genvar gi;

    // Popcount of the current byte; only meaningful while it is the mask byte.
    always_comb begin
        mask_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            mask_pop = mask_pop + {3'b000, adc_in.adc_data[i]};
        end
    end

    assign exp_len   = 9'd2 + {4'b0000, mask_pop, 1'b0};
    assign len_bad   = (exp_len != {1'b0, len_reg});
    assign ch_onehot = 8'(8'd1 << ch_reg);
    assign rem_mask  = work_mask_reg & ~ch_onehot;

    // The first channel comes from the mask byte itself, later ones from
    // whatever is left in the working mask after the current sample.
    assign pick_vec = (state_reg == S_MASK) ? adc_in.adc_data : rem_mask;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_lowest
            localparam logic [7:0] C_BELOW = 8'((9'd1 << gi) - 9'd1);
            assign pick_onehot[gi] = pick_vec[gi] & ~(|(pick_vec & C_BELOW));
        end
        for (gi = 0; gi < 3; gi++) begin : g_enc
            assign pick_idx[gi] = |(pick_onehot & C_ENC_SEL[gi]);
        end
    endgenerate

    // Packet parser: advances only on valid bytes, outputs are registered pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= S_IDLE;
            len_reg        <= 8'd0;
            work_mask_reg  <= 8'd0;
            ch_reg         <= 3'd0;
            msb_reg        <= 8'd0;
            chnl_idx_reg   <= 3'd0;
            chnl_data_reg  <= 16'd0;
            chnl_valid_reg <= 1'b0;
            pkt_done_reg   <= 1'b0;
            pkt_err_reg    <= 1'b0;
        end else begin
            chnl_valid_reg <= 1'b0;
            pkt_done_reg   <= 1'b0;
            pkt_err_reg    <= 1'b0;
            if (adc_in.adc_valid) begin
                case (state_reg)
                    S_IDLE: begin
                        if (adc_in.adc_data == P_HEADER) begin
                            if (adc_in.adc_last) begin
                                // a header alone is not a packet
                                pkt_err_reg <= 1'b1;
                            end else begin
                                len_reg   <= adc_in.adc_len;
                                state_reg <= S_MASK;
                            end
                        end else begin
                            pkt_err_reg <= 1'b1;
                            state_reg   <= adc_in.adc_last ? S_IDLE : S_DROP;
                        end
                    end
                    S_MASK: begin
                        work_mask_reg <= adc_in.adc_data;
                        if (len_bad) begin
                            pkt_err_reg <= 1'b1;
                            state_reg   <= adc_in.adc_last ? S_IDLE : S_DROP;
                        end else if (adc_in.adc_data == 8'd0) begin
                            // empty packet: must end right here
                            if (adc_in.adc_last) begin
                                pkt_done_reg <= 1'b1;
                                state_reg    <= S_IDLE;
                            end else begin
                                pkt_err_reg <= 1'b1;
                                state_reg   <= S_DROP;
                            end
                        end else if (adc_in.adc_last) begin
                            pkt_err_reg <= 1'b1;
                            state_reg   <= S_IDLE;
                        end else begin
                            ch_reg    <= pick_idx;
                            state_reg <= S_HI;
                        end
                    end
                    S_HI: begin
                        msb_reg <= adc_in.adc_data;
                        if (adc_in.adc_last) begin
                            pkt_err_reg <= 1'b1;
                            state_reg   <= S_IDLE;
                        end else begin
                            state_reg <= S_LO;
                        end
                    end
                    S_LO: begin
                        // the sample is emitted even if the packet turns out short
                        chnl_valid_reg <= 1'b1;
                        chnl_idx_reg   <= ch_reg;
                        chnl_data_reg  <= {msb_reg, adc_in.adc_data};
                        work_mask_reg  <= rem_mask;
                        if (rem_mask == 8'd0) begin
                            if (adc_in.adc_last) begin
                                pkt_done_reg <= 1'b1;
                                state_reg    <= S_IDLE;
                            end else begin
                                pkt_err_reg <= 1'b1;
                                state_reg   <= S_DROP;
                            end
                        end else if (adc_in.adc_last) begin
                            pkt_err_reg <= 1'b1;
                            state_reg   <= S_IDLE;
                        end else begin
                            ch_reg    <= pick_idx;
                            state_reg <= S_HI;
                        end
                    end
                    S_DROP: begin
                        // error already reported; just find the packet end
                        if (adc_in.adc_last) begin
                            state_reg <= S_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating count of error pulses, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_reg <= '0;
        end else if (pkt_err_reg && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign o_chnl_idx   = chnl_idx_reg;
    assign o_chnl_data  = chnl_data_reg;
    assign o_chnl_valid = chnl_valid_reg;
    assign o_pkt_done   = pkt_done_reg;
    assign o_pkt_err    = pkt_err_reg;
    assign o_err_cnt    = err_cnt_reg;

endmodule
